// File: rtl/fmap_wr_sched.sv
// fmap_wr_sched: arbitrates conv1/expand producer streams onto the A/B feature-map bank groups
module fmap_wr_sched #(
    parameter int NUM_SETS = 8,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter int SET_W    = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic                abort_i,
    input  logic                conv1_valid_i,
    output logic                conv1_ready_o,
    input  logic                e1_valid_i,
    output logic                e1_ready_o,
    input  logic                e3_valid_i,
    output logic                e3_ready_o,
    output logic [NUM_SETS-1:0] ena_a_o,
    output logic [NUM_SETS-1:0] wea_a_o,
    output logic [ADDR_W-1:0]   addr_a_o,
    output logic [NUM_SETS-1:0] ena_b_o,
    output logic [NUM_SETS-1:0] wea_b_o,
    output logic [ADDR_W-1:0]   addr_b_o,
    output logic [1:0]          din_sel_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                start_err_o
);
    typedef enum logic [1:0] {IDLE, CONV, EXPAND, DONE} state_t;

    state_t            state_q, state_d;
    logic [SET_W-1:0]  set_a_q, set_a_d, set_b_q, set_b_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic              fin_a_q, fin_a_d, fin_b_q, fin_b_d;
    logic              acc_a, acc_b, wrap_a, wrap_b, last_a, last_b;

    assign busy_o        = (state_q == CONV) || (state_q == EXPAND);
    assign done_o        = state_q == DONE;
    assign start_err_o   = start_i && (state_q != IDLE);
    assign din_sel_o     = (state_q == CONV) ? 2'd1 : (state_q == EXPAND) ? 2'd2 : 2'd0;
    assign conv1_ready_o = state_q == CONV;
    assign e1_ready_o    = (state_q == EXPAND) && !fin_a_q;
    assign e3_ready_o    = (state_q == EXPAND) && !fin_b_q;

    // In CONV both groups are fed by conv1, so their counters advance in lockstep and addr_b mirrors addr_a.
    assign acc_a = !abort_i && ((conv1_ready_o && conv1_valid_i) || (e1_ready_o && e1_valid_i));
    assign acc_b = !abort_i && ((conv1_ready_o && conv1_valid_i) || (e3_ready_o && e3_valid_i));

    assign wrap_a = addr_a_q == ADDR_W'(DEPTH - 1);
    assign wrap_b = addr_b_q == ADDR_W'(DEPTH - 1);
    assign last_a = set_a_q == SET_W'(NUM_SETS - 1);
    assign last_b = set_b_q == SET_W'(NUM_SETS - 1);

    assign ena_a_o  = acc_a ? (NUM_SETS'(1) << set_a_q) : '0;
    assign wea_a_o  = ena_a_o;
    assign ena_b_o  = acc_b ? (NUM_SETS'(1) << set_b_q) : '0;
    assign wea_b_o  = ena_b_o;
    assign addr_a_o = addr_a_q;
    assign addr_b_o = addr_b_q;

    // Next-state: counter advance on accept, layer completion, and clearing on idle/done/abort.
    always_comb begin
        state_d  = state_q;
        set_a_d  = set_a_q;
        addr_a_d = addr_a_q;
        fin_a_d  = fin_a_q;
        set_b_d  = set_b_q;
        addr_b_d = addr_b_q;
        fin_b_d  = fin_b_q;
        if (acc_a) begin
            addr_a_d = wrap_a ? '0 : addr_a_q + ADDR_W'(1);
            set_a_d  = (wrap_a && !last_a) ? set_a_q + SET_W'(1) : set_a_q;
            fin_a_d  = fin_a_q || (wrap_a && last_a);
        end
        if (acc_b) begin
            addr_b_d = wrap_b ? '0 : addr_b_q + ADDR_W'(1);
            set_b_d  = (wrap_b && !last_b) ? set_b_q + SET_W'(1) : set_b_q;
            fin_b_d  = fin_b_q || (wrap_b && last_b);
        end
        if (state_q == IDLE && start_i) state_d = mode_i ? EXPAND : CONV;
        if (busy_o && fin_a_d && fin_b_d) state_d = DONE;
        if (state_q == DONE) state_d = IDLE;
        if (abort_i || state_q == IDLE || state_q == DONE) begin
            set_a_d  = '0;
            addr_a_d = '0;
            fin_a_d  = 1'b0;
            set_b_d  = '0;
            addr_b_d = '0;
            fin_b_d  = 1'b0;
        end
        if (abort_i) state_d = IDLE;
    end

    // State and counter registers; async reset discards any partially written layer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            set_a_q  <= '0;
            addr_a_q <= '0;
            fin_a_q  <= 1'b0;
            set_b_q  <= '0;
            addr_b_q <= '0;
            fin_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            set_a_q  <= set_a_d;
            addr_a_q <= addr_a_d;
            fin_a_q  <= fin_a_d;
            set_b_q  <= set_b_d;
            addr_b_q <= addr_b_d;
            fin_b_q  <= fin_b_d;
        end
    end
endmodule

// File: tb/tb_fmap_wr_sched.sv
// tb_fmap_wr_sched: directed checks of fmap_wr_sched with NUM_SETS=2, DEPTH=4
module tb_fmap_wr_sched;
    logic       clk, rst_n, start, mode, abort;
    logic       conv1_valid, conv1_ready, e1_valid, e1_ready, e3_valid, e3_ready;
    logic [1:0] ena_a, wea_a, ena_b, wea_b, addr_a, addr_b, din_sel;
    logic       busy, done, start_err;
    int         errors = 0;
    int         checks = 0;
    int         n;

    fmap_wr_sched #(.NUM_SETS(2), .DEPTH(4), .ADDR_W(2), .SET_W(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .abort_i(abort),
        .conv1_valid_i(conv1_valid), .conv1_ready_o(conv1_ready),
        .e1_valid_i(e1_valid), .e1_ready_o(e1_ready),
        .e3_valid_i(e3_valid), .e3_ready_o(e3_ready),
        .ena_a_o(ena_a), .wea_a_o(wea_a), .addr_a_o(addr_a),
        .ena_b_o(ena_b), .wea_b_o(wea_b), .addr_b_o(addr_b),
        .din_sel_o(din_sel), .busy_o(busy), .done_o(done), .start_err_o(start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int s);
        return (s == 0) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        rst_n = 0; start = 0; mode = 0; abort = 0;
        conv1_valid = 0; e1_valid = 0; e3_valid = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ena_a", ena_a, 0);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_rdy", {conv1_ready, e1_ready, e3_ready}, 0);
        chk("rst_din_sel", din_sel, 0);
        @(negedge clk); rst_n = 1; #1;
        chk("idle_busy", busy, 0);
        // conv1 layer with valid held high
        @(negedge clk); start = 1; mode = 0; #1;
        chk("idle_start_err", start_err, 0);
        @(negedge clk); start = 0; conv1_valid = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("conv_ena_a", ena_a, oh(k / 4));
            chk("conv_ena_b", ena_b, oh(k / 4));
            chk("conv_wea_a", wea_a, oh(k / 4));
            chk("conv_addr_a", addr_a, k % 4);
            chk("conv_addr_b", addr_b, k % 4);
            chk("conv_rdy", conv1_ready, 1);
            chk("conv_din_sel", din_sel, 1);
            chk("conv_done", done, 0);
            @(negedge clk);
        end
        #1;
        chk("conv_done_pulse", done, 1);
        chk("conv_done_busy", busy, 0);
        chk("conv_done_rdy", conv1_ready, 0);
        chk("conv_done_ena", ena_a, 0);
        @(negedge clk); conv1_valid = 0; #1;
        chk("conv_after_done", done, 0);
        // expand layer, e3 valid on alternate cycles
        @(negedge clk); start = 1; mode = 1; #1;
        @(negedge clk); start = 0; e1_valid = 1;
        for (int c = 0; c < 15; c++) begin
            e3_valid = (c % 2 == 0);
            #1;
            n = (c + 1) / 2;
            chk("exp_e1_ready", e1_ready, c < 8);
            chk("exp_ena_a", ena_a, (c < 8) ? oh(c / 4) : 2'b00);
            if (c < 8) chk("exp_addr_a", addr_a, c % 4);
            chk("exp_ena_b", ena_b, e3_valid ? oh(n / 4) : 2'b00);
            chk("exp_addr_b", addr_b, n % 4);
            chk("exp_e3_ready", e3_ready, 1);
            chk("exp_din_sel", din_sel, 2);
            chk("exp_done", done, 0);
            @(negedge clk);
        end
        e1_valid = 0; e3_valid = 0; #1;
        chk("exp_done_pulse", done, 1);
        chk("exp_done_busy", busy, 0);
        chk("exp_done_rdy", {e1_ready, e3_ready}, 0);
        @(negedge clk); #1;
        chk("exp_after_done", done, 0);
        chk("exp_after_sel", din_sel, 0);
        // conv1 with valid pattern 1,0,0,1
        @(negedge clk); start = 1; mode = 0; #1;
        @(negedge clk); start = 0;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            conv1_valid = (c % 4 == 0) || (c % 4 == 3);
            #1;
            chk("stall_wea_a", wea_a, conv1_valid ? oh(n / 4) : 2'b00);
            chk("stall_wea_b", wea_b, conv1_valid ? oh(n / 4) : 2'b00);
            chk("stall_addr_a", addr_a, n % 4);
            chk("stall_done", done, 0);
            if (conv1_valid) n++;
            @(negedge clk);
        end
        conv1_valid = 0; #1;
        chk("stall_done_pulse", done, 1);
        // start while busy, then abort at set 1 addr 1
        @(negedge clk); start = 1; mode = 0; #1;
        @(negedge clk); start = 0; conv1_valid = 1; #1;
        chk("serr_a0", addr_a, 0);
        @(negedge clk); #1;
        chk("serr_a1", addr_a, 1);
        @(negedge clk); conv1_valid = 0; start = 1; #1;
        chk("serr_pulse", start_err, 1);
        chk("serr_addr", addr_a, 2);
        chk("serr_ena", ena_a, 0);
        chk("serr_busy", busy, 1);
        @(negedge clk); start = 0; conv1_valid = 1; #1;
        chk("serr_clear", start_err, 0);
        chk("serr_hold_addr", addr_a, 2);
        chk("serr_ena2", ena_a, 2'b01);
        @(negedge clk); #1;
        chk("serr_a3", addr_a, 3);
        @(negedge clk); #1;
        chk("abt_set1_ena", ena_a, 2'b10);
        chk("abt_set1_addr", addr_a, 0);
        @(negedge clk); abort = 1; #1;
        chk("abt_addr", addr_a, 1);
        chk("abt_wea_a", wea_a, 0);
        chk("abt_wea_b", wea_b, 0);
        @(negedge clk); abort = 0; conv1_valid = 0; #1;
        chk("abt_busy", busy, 0);
        chk("abt_done", done, 0);
        chk("abt_addr_a", addr_a, 0);
        chk("abt_addr_b", addr_b, 0);
        chk("abt_rdy", conv1_ready, 0);
        @(negedge clk); start = 1; #1;
        @(negedge clk); start = 0; conv1_valid = 1; #1;
        chk("restart_addr", addr_a, 0);
        chk("restart_ena", ena_a, 2'b01);
        @(negedge clk); abort = 1; conv1_valid = 0; #1;
        @(negedge clk); abort = 0; #1;
        chk("restart_abt_busy", busy, 0);
        // async reset mid-expand
        @(negedge clk); start = 1; mode = 1; #1;
        @(negedge clk); start = 0; e1_valid = 1; e3_valid = 1; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("arst_pre_addr", addr_a, 2);
        #2 rst_n = 0;
        #1;
        chk("arst_ena", {ena_a, ena_b}, 0);
        chk("arst_addr", {addr_a, addr_b}, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", {e1_ready, e3_ready}, 0);
        chk("arst_din_sel", din_sel, 0);
        @(negedge clk); rst_n = 1; #1;
        chk("arst_rel_rdy", {e1_ready, e3_ready}, 0);
        chk("arst_rel_busy", busy, 0);
        @(negedge clk); #1;
        chk("arst_idle_rdy", e3_ready, 0);
        chk("arst_idle_addr", addr_b, 0);
        e1_valid = 0; e3_valid = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fmap_wr_sched.md
Name: fmap_wr_sched

Overview:
- Single-clock write scheduler for the feature-map bank array of the fire-module accelerator.
- The array has two groups (A and B) of NUM_SETS RAM sets, each set DEPTH words deep.
- Arbitrates producer streams (conv1, expand1x1, expand3x3) onto the groups and generates per-set enables, write enables, shared write addresses and the datapath input-select.
- Replaces gated producer clocks with valid/ready handshakes in one clk domain.

Parameters:
- NUM_SETS, 8, RAM sets per group.
- DEPTH, 1024, words per set (power of two).
- ADDR_W, 10, write address width, equal to log2(DEPTH).
- SET_W, 3, set index width, equal to log2(NUM_SETS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that launches a layer write; honoured only in IDLE.
- mode  in  1  sampled at start; 0 = conv1 (mirror to A and B), 1 = expand (e1 to A, e3 to B).
- abort  in  1  synchronous; returns to IDLE next edge.
- conv1_valid  in  1 / conv1_ready  out  1  conv1 stream handshake.
- e1_valid  in  1 / e1_ready  out  1  expand1x1 stream handshake.
- e3_valid  in  1 / e3_ready  out  1  expand3x3 stream handshake.
- ena_a, wea_a  out  NUM_SETS  group A per-set enable / write enable (one-hot or zero).
- addr_a  out  ADDR_W  group A write address.
- ena_b, wea_b  out  NUM_SETS  group B per-set enable / write enable.
- addr_b  out  ADDR_W  group B write address.
- din_sel  out  2  datapath mux: 0 = zero, 1 = conv1 to A and B, 2 = e1 to A and e3 to B.
- busy  out  1  high in CONV and EXPAND.
- done  out  1  one-cycle pulse at layer completion.
- start_err  out  1  one-cycle pulse when start arrives outside IDLE.

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; all outputs 0; every ready low.
- FSM states: IDLE, CONV, EXPAND, DONE.
- IDLE:
  - start with mode=0 goes to CONV; start with mode=1 goes to EXPAND.
  - Counters (set_a, addr_a, set_b, addr_b) cleared on entry.
  - din_sel=0.
- Accept rule: a beat is accepted when valid & ready on the same edge.
  - ena and wea are combinational: decoded from the registered set index and ANDed with accept.
  - The RAM captures data on the same edge as the accept (zero-cycle latency).
  - addr_a and addr_b are registered outputs.
- CONV:
  - conv1_ready=1; e1_ready=e3_ready=0; din_sel=1.
  - On accept: ena_a[set_a]=wea_a[set_a]=ena_b[set_a]=wea_b[set_a]=1.
  - addr_b mirrors addr_a.
  - Address increments per accept. At DEPTH-1 the address wraps to 0 and the set index increments.
  - Accept at set NUM_SETS-1, addr DEPTH-1 moves to DONE; conv1_ready drops the next cycle.
- EXPAND:
  - din_sel=2; group A is driven only by e1 and group B only by e3.
  - Each group has its own set/address counter and a fin_a / fin_b flag.
  - e1_ready = !fin_a; e3_ready = !fin_b. Simultaneous accepts are legal and independent.
  - Each stream follows the same wrap and set-increment rule as CONV.
  - Final word of a group sets its fin flag. When fin_a & fin_b, move to DONE; a stream finishing first idles with ready low.
- DONE: done=1 for one cycle; busy=0; readies low; return to IDLE.
- Stalls: valid low holds all counters; ena and wea stay low.
- start outside IDLE: ignored; start_err=1 for one cycle.
- abort has priority over accept on the same edge:
  - No write is issued that cycle (ena/wea forced 0).
  - Counters clear and the state goes to IDLE; no done pulse.
- Async reset mid-operation: immediate return to reset values; a partially written layer is discarded.
- Counters never exceed DEPTH-1 / NUM_SETS-1; no wrap past the last set.
- Total beats per stream per layer = NUM_SETS*DEPTH.

Test Plan:
- NUM_SETS=2, DEPTH=4; start, mode=0, conv1_valid held high:
  - 8 accepts; set 0 at addr 0..3, then set 1 at addr 0..3, with ena_a==ena_b each cycle.
  - done pulses 1 cycle after the 8th accept; busy low after.
- Same params, mode=1; e1_valid high every cycle, e3_valid high on alternate cycles:
  - e1_ready drops after 8 accepts while e3 continues.
  - done pulses only after the 8th e3 accept; group B addresses follow 0..3, 0..3.
- conv1_valid toggling 1,0,0,1:
  - Address advances only on accept cycles; wea low on stall cycles; 8 accepts still complete the layer.
- start pulsed while busy in CONV at set 0 addr 2:
  - start_err=1 for one cycle; state and counters unchanged.
- abort asserted with conv1_valid high at set 1 addr 1:
  - No wea that cycle; next cycle IDLE with counters 0 and no done.
  - A following start restarts at set 0 addr 0.
- rst driven low asynchronously mid-EXPAND (not clock-aligned):
  - All outputs 0 immediately.
  - After rst high, IDLE; readies low until the next start.
